// File: rtl/dpctrl_pkg.sv
// Shared types for the datapath control sequencer: opcodes, FSM states
// and the latched command bundle.
package dpctrl_pkg;

    localparam int DP_ADDR_W = 3;
    localparam int DP_CNT_W  = 4;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_EXEC = 2'b10;
    localparam logic [1:0] OP_OUT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WRITE,
        S_OUT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [1:0]           op;
        logic [DP_ADDR_W-1:0] rd;
        logic [DP_ADDR_W-1:0] ra;
        logic [DP_ADDR_W-1:0] rb;
        logic [1:0]           alu;
        logic                 shift;
        logic [DP_CNT_W-1:0]  cnt;
    } cmd_t;

endpackage

// File: rtl/dpctrl_cmd_queue.sv
// Two-entry command FIFO placed in front of the sequencer FSM.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module dpctrl_cmd_queue
    import dpctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  cmd_t data_i,
    input  logic pop_i,
    output cmd_t data_o,
    output logic empty_o,
    output logic full_o
);

    cmd_t       mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Command sequencer driving the regfile/ALU/shifter datapath controls.
// Define DPCTRL_CMD_QUEUE_EN to add a 2-entry command FIFO ahead of the FSM.
module datapath_ctrl
    import dpctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DP_ADDR_W,
    parameter int CNT_WIDTH  = DP_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_ra,
    input  logic [ADDR_WIDTH-1:0] cmd_rb,
    input  logic [1:0]            cmd_alu,
    input  logic                  cmd_shift,
    input  logic [CNT_WIDTH-1:0]  cmd_cnt,
    output logic                  IE,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] WA,
    output logic                  REA,
    output logic [ADDR_WIDTH-1:0] RAA,
    output logic                  REB,
    output logic [ADDR_WIDTH-1:0] RAB,
    output logic [1:0]            alu_op,
    output logic                  shift_en,
    output logic                  OE,
    output logic                  busy,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] ra_q, ra_d;
    logic [ADDR_WIDTH-1:0] rb_q, rb_d;
    logic [1:0]            alu_q, alu_d;
    logic                  shift_q, shift_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    cmd_t                  cmd_in;
    cmd_t                  src;
    logic                  src_valid;
    logic                  accept;
    logic [CNT_WIDTH-1:0]  src_cnt;

    logic                  ie_d, we_d, rea_d, reb_d;
    logic                  shift_en_d, oe_d, busy_d, done_d;
    logic [ADDR_WIDTH-1:0] wa_d, raa_d, rab_d;
    logic [1:0]            alu_op_d;

    always_comb begin
        cmd_in       = '0;
        cmd_in.op    = cmd_op;
        cmd_in.rd    = DP_ADDR_W'(cmd_rd);
        cmd_in.ra    = DP_ADDR_W'(cmd_ra);
        cmd_in.rb    = DP_ADDR_W'(cmd_rb);
        cmd_in.alu   = cmd_alu;
        cmd_in.shift = cmd_shift;
        cmd_in.cnt   = DP_CNT_W'(cmd_cnt);
    end

`ifdef DPCTRL_CMD_QUEUE_EN
    logic q_push;
    logic q_empty;
    logic q_full;

    assign q_push    = cmd_valid && !q_full;
    assign src_valid = !q_empty;
    assign cmd_ready = !q_full;

    dpctrl_cmd_queue u_cmd_queue (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (q_push),
        .data_i  (cmd_in),
        .pop_i   (accept),
        .data_o  (src),
        .empty_o (q_empty),
        .full_o  (q_full)
    );
`else
    logic ready_q;

    assign src       = cmd_in;
    assign src_valid = cmd_valid;
    assign cmd_ready = ready_q;

    // Ready mirrors "next state is IDLE" so it stays a flop output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_d == S_IDLE);
        end
    end
`endif

    assign accept  = (state_q == S_IDLE) && src_valid;
    assign src_cnt = CNT_WIDTH'(src.cnt);

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        alu_d   = alu_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rd_d    = ADDR_WIDTH'(src.rd);
                    ra_d    = ADDR_WIDTH'(src.ra);
                    rb_d    = ADDR_WIDTH'(src.rb);
                    alu_d   = src.alu;
                    shift_d = src.shift;
                    cnt_d   = (src_cnt == '0) ? CNT_WIDTH'(1) : src_cnt;
                    unique case (src.op)
                        OP_LOAD: state_d = S_LOAD;
                        OP_EXEC: state_d = S_READ;
                        OP_OUT:  state_d = S_OUT;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_LOAD:  state_d = S_DONE;
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                if (cnt_q > CNT_WIDTH'(1)) begin
                    cnt_d   = cnt_q - CNT_WIDTH'(1);
                    state_d = S_READ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_OUT:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Controls are decoded from the state being entered, then registered.
    always_comb begin
        ie_d       = 1'b0;
        we_d       = 1'b0;
        wa_d       = '0;
        rea_d      = 1'b0;
        raa_d      = '0;
        reb_d      = 1'b0;
        rab_d      = '0;
        alu_op_d   = 2'b00;
        shift_en_d = 1'b0;
        oe_d       = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_d != S_IDLE);
        unique case (state_d)
            S_LOAD: begin
                ie_d = 1'b1;
                we_d = 1'b1;
                wa_d = rd_d;
            end
            S_READ, S_WRITE, S_OUT: begin
                rea_d      = 1'b1;
                reb_d      = 1'b1;
                raa_d      = ra_d;
                rab_d      = rb_d;
                alu_op_d   = alu_d;
                shift_en_d = shift_d;
                we_d       = (state_d == S_WRITE);
                oe_d       = (state_d == S_OUT);
                if (state_d != S_OUT) begin
                    wa_d = rd_d;
                end
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            alu_q    <= 2'b00;
            shift_q  <= 1'b0;
            cnt_q    <= '0;
            IE       <= 1'b0;
            WE       <= 1'b0;
            WA       <= '0;
            REA      <= 1'b0;
            RAA      <= '0;
            REB      <= 1'b0;
            RAB      <= '0;
            alu_op   <= 2'b00;
            shift_en <= 1'b0;
            OE       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            alu_q    <= alu_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            IE       <= ie_d;
            WE       <= we_d;
            WA       <= wa_d;
            REA      <= rea_d;
            RAA      <= raa_d;
            REB      <= reb_d;
            RAB      <= rab_d;
            alu_op   <= alu_op_d;
            shift_en <= shift_en_d;
            OE       <= oe_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: directed and random commands
// compared against a per-cycle expected control trace.
module tb_datapath_ctrl;

    localparam int AW = 3;
    localparam int CW = 4;

`ifdef DPCTRL_CMD_QUEUE_EN
    localparam logic QR = 1'b1;
`else
    localparam logic QR = 1'b0;
`endif

    typedef logic [19:0] vec_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_rd = '0;
    logic [AW-1:0] cmd_ra = '0;
    logic [AW-1:0] cmd_rb = '0;
    logic [1:0]    cmd_alu = 2'b00;
    logic          cmd_shift = 1'b0;
    logic [CW-1:0] cmd_cnt = '0;
    logic          IE, WE, REA, REB, shift_en, OE, busy, done;
    logic [AW-1:0] WA, RAA, RAB;
    logic [1:0]    alu_op;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    datapath_ctrl #(
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_alu   (cmd_alu),
        .cmd_shift (cmd_shift),
        .cmd_cnt   (cmd_cnt),
        .IE        (IE),
        .WE        (WE),
        .WA        (WA),
        .REA       (REA),
        .RAA       (RAA),
        .REB       (REB),
        .RAB       (RAB),
        .alu_op    (alu_op),
        .shift_en  (shift_en),
        .OE        (OE),
        .busy      (busy),
        .done      (done)
    );

    function automatic vec_t mk(
        input logic ie, input logic we, input logic [2:0] wa,
        input logic rea, input logic [2:0] raa,
        input logic reb, input logic [2:0] rab,
        input logic [1:0] alu, input logic sh, input logic oe,
        input logic bsy, input logic dn, input logic rdy);
        return {ie, we, wa, rea, raa, reb, rab, alu, sh, oe, bsy, dn, rdy};
    endfunction

    function automatic vec_t obs();
        return {IE, WE, WA, REA, RAA, REB, RAB, alu_op,
                shift_en, OE, busy, done, cmd_ready};
    endfunction

    function automatic vec_t idle_v();
        return mk(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0,
                  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic scramble();
        cmd_op    = 2'($urandom);
        cmd_rd    = 3'($urandom);
        cmd_ra    = 3'($urandom);
        cmd_rb    = 3'($urandom);
        cmd_alu   = 2'($urandom);
        cmd_shift = 1'($urandom);
        cmd_cnt   = 4'($urandom);
    endtask

    // Expected cycle-by-cycle control vectors for one command.
    task automatic build_trace(
        input logic [1:0] op, input logic [2:0] rd, input logic [2:0] ra,
        input logic [2:0] rb, input logic [1:0] alu, input logic sh,
        input int n, output vec_t q[$]);
        q = {};
        case (op)
            2'b01: q.push_back(mk(1'b1, 1'b1, rd, 1'b0, 3'd0, 1'b0, 3'd0,
                                  2'd0, 1'b0, 1'b0, 1'b1, 1'b0, QR));
            2'b10: begin
                for (int i = 0; i < n; i++) begin
                    q.push_back(mk(1'b0, 1'b0, rd, 1'b1, ra, 1'b1, rb,
                                   alu, sh, 1'b0, 1'b1, 1'b0, QR));
                    q.push_back(mk(1'b0, 1'b1, rd, 1'b1, ra, 1'b1, rb,
                                   alu, sh, 1'b0, 1'b1, 1'b0, QR));
                end
            end
            2'b11: q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b1, ra, 1'b1, rb,
                                  alu, sh, 1'b1, 1'b1, 1'b0, QR));
            default: ;
        endcase
        q.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0,
                       2'd0, 1'b0, 1'b0, 1'b1, 1'b1, QR));
    endtask

    task automatic run_cmd(
        input string tag, input logic [1:0] op, input logic [2:0] rd,
        input logic [2:0] ra, input logic [2:0] rb, input logic [1:0] alu,
        input logic sh, input logic [3:0] cnt, input int abort_at);
        vec_t q[$];
        int   n;
        int   lat;
        int   we_n;
        int   exp_lat;
        int   exp_we;
        n       = (cnt == 4'd0) ? 1 : int'(cnt);
        exp_lat = (op == 2'b00) ? 1 : (op == 2'b10) ? 2 * n + 1 : 2;
        exp_we  = (op == 2'b01) ? 1 : (op == 2'b10) ? n : 0;
        build_trace(op, rd, ra, rb, alu, sh, n, q);
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_alu   = alu;
        cmd_shift = sh;
        cmd_cnt   = cnt;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        scramble();
`ifdef DPCTRL_CMD_QUEUE_EN
        chk({tag, " queued"}, 32'(obs()), 32'(idle_v()));
        step();
`endif
        lat  = 0;
        we_n = 0;
        for (int i = 0; i < q.size(); i++) begin
            chk({tag, " trace"}, 32'(obs()), 32'(q[i]));
            if (WE) we_n++;
            if (done && lat == 0) lat = i + 1;
            if (i == abort_at) begin
                cmd_valid = 1'b0;
                RST = 1'b1;
                step();
                RST = 1'b0;
                chk({tag, " abort"}, 32'(obs()), 32'(idle_v()));
                for (int k = 0; k < 4; k++) begin
                    step();
                    chk({tag, " post-abort"}, 32'(obs()), 32'(idle_v()));
                end
                return;
            end
            scramble();
`ifndef DPCTRL_CMD_QUEUE_EN
            cmd_valid = 1'($urandom);
`endif
            step();
        end
        cmd_valid = 1'b0;
        chk({tag, " idle"}, 32'(obs()), 32'(idle_v()));
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " we-count"}, 32'(we_n), 32'(exp_we));
    endtask

    initial begin
        RST       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_rd    = 3'd3;
        step();
        chk("rst cycle1", 32'(obs()), 32'(idle_v()));
        step();
        chk("rst cycle2", 32'(obs()), 32'(idle_v()));
        RST       = 1'b0;
        cmd_valid = 1'b0;
        chk("rst release", 32'(obs()), 32'(idle_v()));
        step();
        chk("rst no-accept", 32'(obs()), 32'(idle_v()));

        run_cmd("load r3", 2'b01, 3'd3, 3'd0, 3'd0, 2'b00, 1'b0, 4'd0, -1);
        run_cmd("exec x3", 2'b10, 3'd2, 3'd2, 3'd5, 2'b01, 1'b1, 4'd3, -1);
        run_cmd("exec cnt0", 2'b10, 3'd6, 3'd1, 3'd7, 2'b10, 1'b0, 4'd0, -1);
        run_cmd("out ra4", 2'b11, 3'd0, 3'd4, 3'd1, 2'b11, 1'b1, 4'd0, -1);
        run_cmd("nop", 2'b00, 3'd5, 3'd5, 3'd5, 2'b11, 1'b1, 4'd9, -1);
        run_cmd("exec x15", 2'b10, 3'd7, 3'd0, 3'd3, 2'b10, 1'b1, 4'd15, -1);
        run_cmd("exec abort", 2'b10, 3'd1, 3'd4, 3'd6, 2'b01, 1'b0, 4'd5, 3);
        run_cmd("load after", 2'b01, 3'd4, 3'd0, 3'd0, 2'b00, 1'b0, 4'd0, -1);

        for (int r = 0; r < 20; r++) begin
            run_cmd("rand", 2'($urandom), 3'($urandom), 3'($urandom),
                    3'($urandom), 2'($urandom), 1'($urandom),
                    4'($urandom), -1);
        end

`ifdef DPCTRL_CMD_QUEUE_EN
        begin
            logic [1:0] qop [3];
            logic [2:0] qrd [3];
            logic [2:0] qra [3];
            logic [3:0] exp_ev [3];
            logic [3:0] ev [$];
            int         pushed;
            int         dones;
            logic       acc;
            logic       full_seen;
            qop[0] = 2'b01; qrd[0] = 3'd5; qra[0] = 3'd0;
            qop[1] = 2'b01; qrd[1] = 3'd6; qra[1] = 3'd0;
            qop[2] = 2'b11; qrd[2] = 3'd0; qra[2] = 3'd2;
            exp_ev[0] = 4'b0101;
            exp_ev[1] = 4'b0110;
            exp_ev[2] = 4'b1010;
            pushed    = 0;
            dones     = 0;
            full_seen = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (pushed < 3) begin
                    cmd_op    = qop[pushed];
                    cmd_rd    = qrd[pushed];
                    cmd_ra    = qra[pushed];
                    cmd_rb    = 3'd1;
                    cmd_alu   = 2'b00;
                    cmd_shift = 1'b0;
                    cmd_cnt   = 4'd1;
                    cmd_valid = 1'b1;
                end else begin
                    cmd_valid = 1'b0;
                end
                if (pushed < 2) chk("q ready", 32'(cmd_ready), 32'd1);
                acc = cmd_valid && cmd_ready;
                step();
                if (acc) pushed++;
                if (pushed == 3 && !full_seen) begin
                    full_seen = 1'b1;
                    chk("q full", 32'(cmd_ready), 32'd0);
                end
                if (done) dones++;
                if (WE) ev.push_back({1'b0, WA});
                if (OE) ev.push_back({1'b1, RAA});
            end
            cmd_valid = 1'b0;
            chk("q pushed", 32'(pushed), 32'd3);
            chk("q dones", 32'(dones), 32'd3);
            chk("q events", 32'(ev.size()), 32'd3);
            for (int i = 0; i < 3; i++) begin
                chk("q order", 32'((i < ev.size()) ? ev[i] : 4'hf),
                    32'(exp_ev[i]));
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
